regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: the ALU result path and the data-memory load path.
- Tracks outstanding destination registers in a scoreboard.
- Raises a read hazard for decode when a source register has a write still in flight.
- Drives the register file's write-enable, destination and data inputs directly.

Parameters:
- DATA_W, 16, width of write data.
- ADDR_W, 3, register address width; 2**ADDR_W registers tracked.
- STARVE_MAX, 3, maximum consecutive load grants while an ALU request waits.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_dest  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this cycle.
- mem_dest  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- issue_en  in  1  decode issues an instruction that will write issue_dest.
- issue_dest  in  ADDR_W  destination of the issued instruction.
- chk_addr_1  in  ADDR_W  decode source operand 1.
- chk_addr_2  in  ADDR_W  decode source operand 2.
- hazard  out  1  a source operand is pending; decode must stall.
- reg_write_en  out  1  register-file write enable.
- reg_write_dest  out  ADDR_W  register-file write address.
- reg_write_data  out  DATA_W  register-file write data.
- pending  out  2**ADDR_W  scoreboard bit per register.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high. While rst=1:
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0.
  - pending=0, starve_cnt=0.
  - alu_ready and mem_ready follow the combinational rule below from the current valids; any transfer in the reset cycle is discarded.
- Grant (combinational from the valids and starve_cnt), at most one ready high per cycle:
  - Neither valid: no grant.
  - One valid: that requester is granted.
  - Both valid: mem wins unless starve_cnt==STARVE_MAX, in which case alu wins.
- Transfer: occurs on a clock edge where valid&&ready. Requesters hold dest and data stable until transfer.
- Starvation counter (2-bit-or-wider, saturating at STARVE_MAX):
  - Increments when mem transfers while alu_valid=1.
  - Clears when alu transfers or when alu_valid=0.
  - Holds otherwise.
- Write output, registered with 1-cycle latency. A transfer at edge N drives reg_write_en/dest/data during cycle N+1. The register file captures the value at the end of N+1, so it is readable from cycle N+2.
  - Transfer with dest==0: it completes the handshake, but reg_write_en stays 0 (r0 is hard-wired zero).
  - No transfer: reg_write_en=0; dest and data hold their previous values.
- Scoreboard, for index i≠0:
  - pending[i] sets at an edge with issue_en&&issue_dest==i.
  - pending[i] clears at an edge with reg_write_en&&reg_write_dest==i.
  - Set and clear on the same index at the same edge: set wins.
  - pending[0] is constant 0.
  - A write to a register that is not pending is performed normally and leaves pending unchanged.
- Hazard (combinational): hazard = (chk_addr_1≠0 && pending[chk_addr_1]) || (chk_addr_2≠0 && pending[chk_addr_2]).
  - Timing consequence: a write committed in cycle N+1 releases hazard in cycle N+2, the same cycle the data becomes readable.
- Reset mid-operation: an accepted but uncommitted write is dropped; the register file is cleared by the same rst, so state stays consistent.
- Back-to-back transfers on consecutive cycles are supported; throughput is one write per cycle.

Test Plan:
1. Reset, then alu_valid=1, alu_dest=3, alu_data=16'h1234 with mem idle -> alu_ready=1 same cycle; next cycle reg_write_en=1, dest=3, data=16'h1234; following cycle reg_write_en=0.
2. Both valid continuously for 8 cycles (mem_dest=1, alu_dest=2) -> grant sequence mem,mem,mem,alu,mem,mem,mem,alu; never both ready high.
3. issue_en with issue_dest=5, then chk_addr_1=5 -> hazard=1 until mem writes r5; hazard drops exactly 2 cycles after the mem transfer edge; pending[5] returns to 0.
4. alu transfer with alu_dest=0, data=16'hFFFF -> alu_ready=1 but reg_write_en stays 0; chk_addr_2=0 never raises hazard.
5. In the same cycle, issue_en with issue_dest=4 while reg_write_en commits r4 -> pending[4] remains 1 and hazard on r4 persists.
6. Assert rst asynchronously mid-cycle, one cycle after a transfer -> reg_write_en, pending and starve_cnt go to 0 immediately without a clock edge; no write emerges after rst deasserts.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the ALU
// and load writeback paths. It keeps a per-register pending scoreboard and
// raises a decode hazard for source operands that are still in flight.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   alu_valid/ready/dest/data  ALU writeback handshake and payload
//   mem_valid/ready/dest/data  load writeback handshake and payload
//   issue_en, issue_dest     decode marks a destination as pending
//   chk_addr_1, chk_addr_2   decode source operands checked for hazard
//   hazard                   combinational stall request to decode
//   reg_write_en/dest/data   registered register-file write port
//   pending                  scoreboard bit per register (bit 0 always 0)
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_dest,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_en,
    input  logic [ADDR_W-1:0]    issue_dest,
    input  logic [ADDR_W-1:0]    chk_addr_1,
    input  logic [ADDR_W-1:0]    chk_addr_2,
    output logic                 hazard,
    output logic                 reg_write_en,
    output logic [ADDR_W-1:0]    reg_write_dest,
    output logic [DATA_W-1:0]    reg_write_data,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int unsigned NREG  = 2**ADDR_W;
    localparam int unsigned CNT_W = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              alu_xfer;
    logic              mem_xfer;
    logic              starved;
    logic [NREG-1:0]   pending_nxt;

    // Grant: loads win ties until the ALU has waited STARVE_MAX grants.
    always_comb begin
        starved   = (starve_cnt == CNT_W'(STARVE_MAX));
        alu_ready = alu_valid && (!mem_valid || starved);
        mem_ready = mem_valid && !alu_ready;
        alu_xfer  = alu_valid && alu_ready;
        mem_xfer  = mem_valid && mem_ready;
    end

    // Starvation counter next state, saturating at STARVE_MAX.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!alu_valid || alu_xfer) begin
            starve_nxt = '0;
        end else if (mem_xfer && !starved) begin
            starve_nxt = starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    // Registered write port; r0 writes complete the handshake but never commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else if (alu_xfer) begin
            reg_write_en   <= (alu_dest != '0);
            reg_write_dest <= alu_dest;
            reg_write_data <= alu_data;
        end else if (mem_xfer) begin
            reg_write_en   <= (mem_dest != '0);
            reg_write_dest <= mem_dest;
            reg_write_data <= mem_data;
        end else begin
            reg_write_en   <= 1'b0;
        end
    end

    // Scoreboard next state: issue sets, commit clears, set wins on a tie.
    always_comb begin
        pending_nxt = pending;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (issue_en && issue_dest == ADDR_W'(i)) begin
                pending_nxt[i] = 1'b1;
            end else if (reg_write_en && reg_write_dest == ADDR_W'(i)) begin
                pending_nxt[i] = 1'b0;
            end
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Hazard releases the cycle after commit, when the data is readable.
    always_comb begin
        hazard = ((chk_addr_1 != '0) && pending[chk_addr_1]) ||
                 ((chk_addr_2 != '0) && pending[chk_addr_2]);
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed stimulus pushes the
// expected register-file writes into a queue; a monitor pops and compares
// each committed write. Directed checks cover grants, hazard and reset.
module tb_regfile_wb_arbiter;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid, mem_valid, issue_en;
    logic              alu_ready, mem_ready, hazard, reg_write_en;
    logic [ADDR_W-1:0] alu_dest, mem_dest, issue_dest, chk_addr_1, chk_addr_2;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] alu_data, mem_data, reg_write_data;
    logic [7:0]        pending;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(3), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_dest(alu_dest), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dest(mem_dest), .mem_data(mem_data),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
        .hazard(hazard),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every committed write must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && reg_write_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got dest=%0d data=0x%0h, expected none",
                         reg_write_dest, reg_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_dest", 32'(reg_write_dest), 32'(e.dest));
                chk("wr_data", 32'(reg_write_data), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gtab;
        gtab = 8'b1000_1000;  // bit i set: ALU granted in cycle i of a tie
        rst = 1'b1;
        {alu_valid, mem_valid, issue_en} = '0;
        {alu_dest, mem_dest, issue_dest, chk_addr_1, chk_addr_2} = '0;
        alu_data = '0;
        mem_data = '0;
        tick();
        tick();
        #3;
        chk("rst_wen",  32'(reg_write_en),   32'd0);
        chk("rst_dest", 32'(reg_write_dest), 32'd0);
        chk("rst_data", 32'(reg_write_data), 32'd0);
        chk("rst_pend", 32'(pending),        32'd0);
        tick();
        rst = 1'b0;

        // 1: single ALU write, one-cycle latency
        tick();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        exp_q.push_back('{dest: 3'd3, data: 16'h1234});
        #3;
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_mem_ready", 32'(mem_ready), 32'd0);
        tick();
        alu_valid = 1'b0;
        #3;
        chk("t1_wen_n1",  32'(reg_write_en),   32'd1);
        chk("t1_dest_n1", 32'(reg_write_dest), 32'd3);
        tick();
        #3;
        chk("t1_wen_n2", 32'(reg_write_en), 32'd0);
        tick();

        // 2: both valid for 8 cycles, starvation-bounded grants
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'hA2A2;
        mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'hB1B1;
        for (int i = 0; i < 8; i++) begin
            #3;
            chk("t2_alu_ready", 32'(alu_ready), 32'(gtab[i]));
            chk("t2_mem_ready", 32'(mem_ready), 32'(!gtab[i]));
            if (gtab[i]) exp_q.push_back('{dest: 3'd2, data: 16'hA2A2});
            else         exp_q.push_back('{dest: 3'd1, data: 16'hB1B1});
            tick();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        tick();

        // 3: hazard held until the load to r5 commits
        issue_en = 1'b1; issue_dest = 3'd5;
        tick();
        issue_en = 1'b0; chk_addr_1 = 3'd5;
        #3;
        chk("t3_hazard_set", 32'(hazard),     32'd1);
        chk("t3_pend5_set",  32'(pending[5]), 32'd1);
        tick();
        mem_valid = 1'b1; mem_dest = 3'd5; mem_data = 16'h5555;
        exp_q.push_back('{dest: 3'd5, data: 16'h5555});
        #3;
        chk("t3_mem_ready", 32'(mem_ready), 32'd1);
        chk("t3_hazard_n0", 32'(hazard),    32'd1);
        tick();
        mem_valid = 1'b0;
        #3;
        chk("t3_hazard_n1", 32'(hazard), 32'd1);
        tick();
        #3;
        chk("t3_hazard_n2", 32'(hazard),     32'd0);
        chk("t3_pend5_clr", 32'(pending[5]), 32'd0);
        chk_addr_1 = 3'd0;
        tick();

        // 4: r0 write and r0 issue are both ignored
        alu_valid = 1'b1; alu_dest = 3'd0; alu_data = 16'hFFFF;
        issue_en = 1'b1; issue_dest = 3'd0;
        #3;
        chk("t4_alu_ready", 32'(alu_ready), 32'd1);
        chk("t4_hazard",    32'(hazard),    32'd0);
        tick();
        alu_valid = 1'b0; issue_en = 1'b0;
        #3;
        chk("t4_wen",    32'(reg_write_en), 32'd0);
        chk("t4_pend",   32'(pending),      32'd0);
        chk("t4_hazard", 32'(hazard),       32'd0);
        tick();

        // 5: issue and commit to r4 on the same edge keep r4 pending
        issue_en = 1'b1; issue_dest = 3'd4;
        tick();
        issue_en = 1'b0;
        alu_valid = 1'b1; alu_dest = 3'd4; alu_data = 16'h4444;
        exp_q.push_back('{dest: 3'd4, data: 16'h4444});
        #3;
        chk("t5_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        issue_en = 1'b1; issue_dest = 3'd4;
        #3;
        chk("t5_wen",  32'(reg_write_en),   32'd1);
        chk("t5_dest", 32'(reg_write_dest), 32'd4);
        tick();
        issue_en = 1'b0; chk_addr_1 = 3'd4;
        #3;
        chk("t5_pend4",  32'(pending[4]), 32'd1);
        chk("t5_hazard", 32'(hazard),     32'd1);
        tick();
        #3;
        chk("t5_hazard_hold", 32'(hazard), 32'd1);
        chk_addr_1 = 3'd0;
        tick();

        // 6: async reset drops an uncommitted write and clears state
        alu_valid = 1'b1; alu_dest = 3'd6; alu_data = 16'h6666;
        mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h1111;
        exp_q.push_back('{dest: 3'd1, data: 16'h1111});
        #3;
        chk("t6_mem_ready_a", 32'(mem_ready), 32'd1);
        tick();
        #3;
        chk("t6_mem_ready_b", 32'(mem_ready), 32'd1);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_wen",  32'(reg_write_en), 32'd0);
        chk("t6_rst_pend", 32'(pending),      32'd0);
        alu_valid = 1'b1;
        #0.5;
        chk("t6_rst_alu_ready", 32'(alu_ready), 32'd1);
        alu_valid = 1'b0;
        #0.5;
        rst = 1'b0;
        tick();
        tick();
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h8888;
        mem_valid = 1'b1; mem_dest = 3'd1; mem_data = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("t6_alu_ready", 32'(alu_ready), 32'(gtab[i]));
            chk("t6_mem_ready", 32'(mem_ready), 32'(!gtab[i]));
            if (gtab[i]) exp_q.push_back('{dest: 3'd2, data: 16'h8888});
            else         exp_q.push_back('{dest: 3'd1, data: 16'h7777});
            tick();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
